prec_scalable_dot_engine: RTL and testbench

Precision-scalable signed dot-product engine and successor to the single-step MAC unit. It accepts a stream of 8-bit activation and 8-bit weight beats over a valid/ready handshake, in 8-, 4- or 2-bit weight-precision mode. It accumulates one vector per transaction into four parametrised, optionally saturating lanes and returns the finished sum over a second valid/ready handshake. It sits between the operand buffer and the output/requantisation stage of the PE array.

---
 rtl/prec_scalable_dot_engine.sv | 219 +++++++++++++++++++++
 tb/tb_prec_scalable_dot_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prec_scalable_dot_engine.sv
// prec_scalable_dot_engine
//   Precision-scalable signed dot-product engine. Streams 8-bit activation /
//   8-bit packed-weight beats and accumulates one vector per transaction into
//   four LANE_W lanes, chained as 1x4, 2x2 or 4x1 lanes depending on the
//   weight precision (8, 4 or 2 bits). The finished sum is then returned.
//
// Handshakes: a beat transfers on an edge where in_valid && in_ready; a result
//   transfers on an edge where out_valid && out_ready. A valid is never
//   withdrawn by the engine before its transfer, and the data it qualifies is
//   held stable until then.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   mode[1:0]          00 = 8-bit, 01 = 2x4-bit, 10 = 4x2-bit, 11 = as 00
//   in_valid/in_ready  beat handshake; in_act, in_wgt, in_last carry the beat
//   out_valid/out_ready result handshake
//   out_result         packed lanes, lane i = out_result[i*LANE_W +: LANE_W]
//   out_ovf            sticky per-lane overflow flags for this vector
//   out_mode           mode the vector was computed in (11 reported as 00)
module prec_scalable_dot_engine #(
    parameter int LANE_W = 14,
    parameter bit SAT    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_act,
    input  logic [7:0]            in_wgt,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*LANE_W-1:0]   out_result,
    output logic [3:0]            out_ovf,
    output logic [1:0]            out_mode
);

    localparam int ACC_W = 4 * LANE_W;
    localparam int GW    = 2 * LANE_W;

    localparam logic [ACC_W-1:0]  F_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  F_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [GW-1:0]     G_MAX = {1'b0, {(GW-1){1'b1}}};
    localparam logic [GW-1:0]     G_MIN = {1'b1, {(GW-1){1'b0}}};
    localparam logic [LANE_W-1:0] L_MAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] L_MIN = {1'b1, {(LANE_W-1){1'b0}}};

    typedef enum logic [1:0] {ST_ACCUM, ST_DRAIN, ST_OUT} state_t;

    state_t state, state_nxt;
    logic   drain_cnt;
    logic   accept, handoff;

    // Datapath state
    logic             first;          // next accepted beat opens a vector
    logic [1:0]       vec_mode;
    logic [1:0]       norm_mode, eff_mode;
    logic             s1_vld, s2_vld;
    logic [7:0]       s1_act, s1_wgt;
    logic [1:0]       s1_mode, s2_mode;
    logic [39:0]      prod_c, s2_prod;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [3:0]       ovf, ovf_nxt;

    assign accept  = in_valid && in_ready;
    assign handoff = out_valid && out_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_ACCUM;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            // Counts the two pipeline-flush cycles spent in DRAIN.
            drain_cnt <= (state == ST_DRAIN);
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCUM: if (accept && in_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_cnt)         state_nxt = ST_OUT;
            ST_OUT:   if (out_ready)         state_nxt = ST_ACCUM;
            default:                         state_nxt = ST_ACCUM;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state == ST_ACCUM);
        out_valid = (state == ST_OUT);
    end

    // Mode is frozen by the first beat of a vector; 11 behaves as 00.
    assign norm_mode = (mode == 2'b11) ? 2'b00 : mode;
    assign eff_mode  = first ? norm_mode : vec_mode;

    // ---------------- Stage 2: products ----------------
    logic signed [15:0] p8;
    logic signed [11:0] p4 [2];
    logic signed [9:0]  p2 [4];

    always_comb begin
        p8 = $signed({{8{s1_act[7]}}, s1_act}) * $signed({{8{s1_wgt[7]}}, s1_wgt});
        for (int g = 0; g < 2; g++)
            p4[g] = $signed({{4{s1_act[7]}}, s1_act}) *
                    $signed({{8{s1_wgt[4*g+3]}}, s1_wgt[4*g +: 4]});
        for (int i = 0; i < 4; i++)
            p2[i] = $signed({{2{s1_act[7]}}, s1_act}) *
                    $signed({{8{s1_wgt[2*i+1]}}, s1_wgt[2*i +: 2]});
    end

    // Products packed by mode so one 40-bit register carries any precision.
    always_comb begin
        case (s1_mode)
            2'b01:   prod_c = {16'b0, p4[1], p4[0]};
            2'b10:   prod_c = {p2[3], p2[2], p2[1], p2[0]};
            default: prod_c = {24'b0, p8};
        endcase
    end

    // ---------------- Stage 3: accumulate ----------------
    // Full-width chain (mode 00)
    logic [ACC_W-1:0] f_add, f_raw, f_res;
    logic             f_ov;
    assign f_add = {{(ACC_W-16){s2_prod[15]}}, s2_prod[15:0]};
    assign f_raw = acc + f_add;
    assign f_ov  = (acc[ACC_W-1] == f_add[ACC_W-1]) && (f_raw[ACC_W-1] != acc[ACC_W-1]);
    assign f_res = (SAT && f_ov) ? (acc[ACC_W-1] ? F_MIN : F_MAX) : f_raw;

    // Two independent double-lane groups (mode 01)
    logic [ACC_W-1:0] g_res;
    logic [1:0]       g_ov;
    for (genvar g = 0; g < 2; g++) begin : g_grp
        logic [GW-1:0] a, p, s;
        assign a = acc[g*GW +: GW];
        assign p = {{(GW-12){s2_prod[g*12+11]}}, s2_prod[g*12 +: 12]};
        assign s = a + p;
        assign g_ov[g] = (a[GW-1] == p[GW-1]) && (s[GW-1] != a[GW-1]);
        assign g_res[g*GW +: GW] = (SAT && g_ov[g]) ? (a[GW-1] ? G_MIN : G_MAX) : s;
    end

    // Four independent lanes (mode 10)
    logic [ACC_W-1:0] l_res;
    logic [3:0]       l_ov;
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [LANE_W-1:0] a, p, s;
        assign a = acc[i*LANE_W +: LANE_W];
        assign p = {{(LANE_W-10){s2_prod[i*10+9]}}, s2_prod[i*10 +: 10]};
        assign s = a + p;
        assign l_ov[i] = (a[LANE_W-1] == p[LANE_W-1]) && (s[LANE_W-1] != a[LANE_W-1]);
        assign l_res[i*LANE_W +: LANE_W] = (SAT && l_ov[i]) ? (a[LANE_W-1] ? L_MIN : L_MAX) : s;
    end

    always_comb begin
        case (s2_mode)
            2'b01: begin
                acc_nxt = g_res;
                ovf_nxt = ovf | {{2{g_ov[1]}}, {2{g_ov[0]}}};
            end
            2'b10: begin
                acc_nxt = l_res;
                ovf_nxt = ovf | l_ov;
            end
            default: begin
                acc_nxt = f_res;
                ovf_nxt = ovf | {4{f_ov}};
            end
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            first    <= 1'b1;
            vec_mode <= 2'b00;
            s1_vld   <= 1'b0;
            s1_act   <= '0;
            s1_wgt   <= '0;
            s1_mode  <= 2'b00;
            s2_vld   <= 1'b0;
            s2_prod  <= '0;
            s2_mode  <= 2'b00;
            acc      <= '0;
            ovf      <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                first   <= in_last;
                s1_act  <= in_act;
                s1_wgt  <= in_wgt;
                s1_mode <= eff_mode;
                if (first) vec_mode <= norm_mode;
            end
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_prod <= prod_c;
                s2_mode <= s1_mode;
            end
            // The pipeline is empty in OUT, so hand-off never races an add.
            if (handoff) begin
                acc <= '0;
                ovf <= '0;
            end else if (s2_vld) begin
                acc <= acc_nxt;
                ovf <= ovf_nxt;
            end
        end
    end

    assign out_result = acc;
    assign out_ovf    = ovf;
    assign out_mode   = vec_mode;

endmodule

// File: tb/tb_prec_scalable_dot_engine.sv
// Directed testbench for prec_scalable_dot_engine (LANE_W = 14).
// Two instances share every input: dut (SAT=1) and dut_w (SAT=0).
module tb_prec_scalable_dot_engine;

    localparam int L = 14;
    localparam int W = 4 * L;

    logic         clk;
    logic         rstn;
    logic [1:0]   mode;
    logic         in_valid;
    logic [7:0]   in_act;
    logic [7:0]   in_wgt;
    logic         in_last;
    logic         out_ready;

    logic         in_ready, out_valid;
    logic [W-1:0] out_result;
    logic [3:0]   out_ovf;
    logic [1:0]   out_mode;

    logic         w_in_ready, w_out_valid;
    logic [W-1:0] w_out_result;
    logic [3:0]   w_out_ovf;
    logic [1:0]   w_out_mode;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;

    prec_scalable_dot_engine #(.LANE_W(L), .SAT(1'b1)) dut (
        .clk(clk), .rstn(rstn), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .in_wgt(in_wgt), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ovf(out_ovf), .out_mode(out_mode)
    );

    prec_scalable_dot_engine #(.LANE_W(L), .SAT(1'b0)) dut_w (
        .clk(clk), .rstn(rstn), .mode(mode),
        .in_valid(in_valid), .in_ready(w_in_ready),
        .in_act(in_act), .in_wgt(in_wgt), .in_last(in_last),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_result(w_out_result), .out_ovf(w_out_ovf), .out_mode(w_out_mode)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int l0, input int l1, input int l2, input int l3);
        logic [W-1:0] r;
        r = {14'(l3), 14'(l2), 14'(l1), 14'(l0)};
        return {8'b0, r};
    endfunction

    function automatic logic [63:0] pack2(input int g0, input int g1);
        logic [W-1:0] r;
        r = {28'(g1), 28'(g0)};
        return {8'b0, r};
    endfunction

    // Present one beat; returns 1 ns after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] w,
                        input logic [1:0] m, input logic last);
        int guard;
        in_valid = 1'b1;
        in_act   = a;
        in_wgt   = w;
        mode     = m;
        in_last  = last;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready stayed low");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Count edges until out_valid is seen (bounded).
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!out_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_valid_timeout: out_valid never rose");
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rstn      = 1'b0;
        mode      = 2'b00;
        in_valid  = 1'b0;
        in_act    = '0;
        in_wgt    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        #2;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_result", out_result, 0);
        check_eq("rst_out_ovf", out_ovf, 0);
        check_eq("rst_out_mode", out_mode, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_in_ready", in_ready, 1);

        // Mode 00: 3 x (100*100) + (-128*-128) = 46384
        repeat (3) send(8'd100, 8'd100, 2'b00, 1'b0);
        send(8'h80, 8'h80, 2'b00, 1'b1);
        check_eq("m00_drain_valid", out_valid, 0);
        check_eq("m00_drain_in_ready", in_ready, 0);
        wait_valid(lat);
        check_eq("m00_latency", 64'(lat), 2);
        check_eq("m00_result", {8'b0, out_result}, {8'b0, 56'(46384)});
        check_eq("m00_ovf", out_ovf, 0);
        check_eq("m00_mode", out_mode, 2'b00);
        handoff();
        check_eq("m00_after_valid", out_valid, 0);
        check_eq("m00_after_in_ready", in_ready, 1);

        // Mode 10: lanes = 5 * {0,1,-2,-1} * 4 beats
        repeat (3) send(8'd5, 8'b11_10_01_00, 2'b10, 1'b0);
        send(8'd5, 8'b11_10_01_00, 2'b10, 1'b1);
        wait_valid(lat);
        check_eq("m10_result", {8'b0, out_result}, pack4(0, 20, -40, -20));
        check_eq("m10_ovf", out_ovf, 0);
        check_eq("m10_mode", out_mode, 2'b10);
        handoff();

        // Mode 01: (-7)*(-7) and (-7)*7, twice; mode on beat 2 must be ignored
        send(8'hF9, 8'h79, 2'b01, 1'b0);
        send(8'hF9, 8'h79, 2'b00, 1'b1);
        wait_valid(lat);
        check_eq("m01_result", {8'b0, out_result}, pack2(98, -98));
        check_eq("m01_ovf", out_ovf, 0);
        check_eq("m01_mode", out_mode, 2'b01);
        handoff();

        // Saturation / wrap on lane 0: (-128) * (-2) = 256 per beat
        repeat (31) send(8'h80, 8'b00_00_00_10, 2'b10, 1'b0);
        repeat (2) @(posedge clk); #1;
        check_eq("sat_31_lane", {8'b0, out_result}, pack4(7936, 0, 0, 0));
        check_eq("sat_31_ovf", out_ovf, 0);
        check_eq("wrap_31_lane", {8'b0, w_out_result}, pack4(7936, 0, 0, 0));
        send(8'h80, 8'b00_00_00_10, 2'b10, 1'b0);
        repeat (2) @(posedge clk); #1;
        check_eq("sat_32_lane", {8'b0, out_result}, pack4(8191, 0, 0, 0));
        check_eq("sat_32_ovf", out_ovf, 4'b0001);
        check_eq("wrap_32_lane", {8'b0, w_out_result}, pack4(-8192, 0, 0, 0));
        check_eq("wrap_32_ovf", w_out_ovf, 4'b0001);
        send(8'h80, 8'b00_00_00_10, 2'b10, 1'b1);
        wait_valid(lat);
        check_eq("sat_final", {8'b0, out_result}, pack4(8191, 0, 0, 0));
        check_eq("sat_final_ovf", out_ovf, 4'b0001);
        check_eq("wrap_final", {8'b0, w_out_result}, pack4(-7936, 0, 0, 0));
        check_eq("wrap_final_ovf", w_out_ovf, 4'b0001);
        check_eq("wrap_final_valid", w_out_valid, 1);
        handoff();
        check_eq("sat_cleared_ovf", out_ovf, 0);

        // Backpressure: 2*3 + (-1)*4 = 2, held for 5 cycles with a beat offered
        send(8'd2, 8'd3, 2'b00, 1'b0);
        send(8'hFF, 8'd4, 2'b00, 1'b1);
        wait_valid(lat);
        in_valid = 1'b1;
        in_act   = 8'd9;
        in_wgt   = 8'd9;
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check_eq("bp_result", {8'b0, out_result}, {8'b0, 56'(2)});
            check_eq("bp_in_ready", in_ready, 0);
            check_eq("bp_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        handoff();
        check_eq("bp_handoff_valid", out_valid, 0);
        check_eq("bp_handoff_in_ready", in_ready, 1);
        check_eq("bp_handoff_cleared", {8'b0, out_result}, 0);
        // Next vector in mode 11 (treated as 00): 3 * (-2) = -6
        send(8'd3, 8'hFE, 2'b11, 1'b1);
        wait_valid(lat);
        check_eq("m11_result", {8'b0, out_result}, {8'b0, 56'(-6)});
        check_eq("m11_mode", out_mode, 2'b00);
        handoff();

        // Reset mid-vector: two of four mode-10 beats, then an async reset
        send(8'd5, 8'h55, 2'b10, 1'b0);
        send(8'd5, 8'h55, 2'b10, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_result", {8'b0, out_result}, 0);
        check_eq("midrst_ovf", out_ovf, 0);
        check_eq("midrst_mode", out_mode, 0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("midrst_result_held", {8'b0, out_result}, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        send(8'd3, 8'd4, 2'b00, 1'b1);
        wait_valid(lat);
        check_eq("postrst_latency", 64'(lat), 2);
        check_eq("postrst_result", {8'b0, out_result}, {8'b0, 56'(12)});
        check_eq("postrst_ovf", out_ovf, 0);
        check_eq("postrst_mode", out_mode, 2'b00);
        handoff();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
